load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Responder side of the data-memory control interface: consumes the MemWrite / MemCtrl command emitted by instruction decode, plus the ALU-computed address and rs2 store data.
- Performs byte/half/word loads and stores against a 32-bit word-addressed data memory with a grant/valid handshake and variable latency.
- On loads, returns the sign- or zero-extended result toward writeback (ResultSrc=1 path).
- Sits between the execute stage and the data memory.

Parameters:
- ADDR_WIDTH, 32, byte address width.
- TIMEOUT_CYCLES, 16, max cycles in REQ+WAIT before error response; 0 disables the timeout.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  core issues a memory command.
- req_ready  out  1  unit can accept a command; high only in IDLE.
- req_write  in  1  MemWrite: 1=store, 0=load.
- req_ctrl  in  3  MemCtrl: size/extension code.
- req_addr  in  ADDR_WIDTH  byte address.
- req_wdata  in  32  store data, low-aligned.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  32  extended load data; 0 for stores and errors.
- rsp_err  out  1  error qualifier, valid with rsp_valid.
- mem_req  out  1  memory request.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_WIDTH  word address; bits[1:0] always 0.
- mem_be  out  4  byte-lane enables.
- mem_wdata  out  32  lane-replicated store data.
- mem_gnt  in  1  memory accepts the request.
- mem_rvalid  in  1  load data valid.
- mem_rdata  in  32  raw word read.

Behaviour:
- Reset: async clear to IDLE. All outputs 0 while rst_n is low, including req_ready. After release, req_ready=1.
- MemCtrl codes: MEM_B=000, MEM_H=001, MEM_W=010, MEM_BU=100, MEM_HU=101. Codes 011/110/111 are illegal: no memory access, rsp_err=1.
- Stores with BU/HU codes behave as B/H.
- Accept on req_valid && req_ready. Command, address and data are latched. Inputs are ignored outside IDLE.
- FSM states:
  - IDLE -> REQ: on accept of a legal, aligned command.
  - IDLE -> RESP: on accept of an illegal or misaligned command (err).
  - REQ: mem_req=1, mem_* held stable until mem_gnt. Store -> RESP. Load -> WAIT.
  - WAIT: mem_req=0. On mem_rvalid, capture the extended data -> RESP.
  - RESP: rsp_valid=1 for exactly one cycle -> IDLE. No back-pressure.
- mem_rvalid is ignored outside WAIT, including late data after a timeout.
- Latency with zero-wait memory (accept at cycle T):
  - Store: mem_req at T+1, rsp_valid at T+2.
  - Load: mem_rvalid no earlier than T+2, rsp_valid one cycle after mem_rvalid.
- Lane mapping (o = addr[1:0]):
  - B: be = 1<<o, wdata = {4{wdata[7:0]}}.
  - H: be = o[1] ? 1100 : 0011, wdata = {2{wdata[15:0]}}.
  - W: be = 1111, wdata unchanged.
- Load extract: selected byte or half shifted to bit 0. B/H sign-extend; BU/HU zero-extend; W passes through.
- Timeout: counter clears on entry to REQ and counts each cycle in REQ/WAIT. Reaching TIMEOUT_CYCLES drops mem_req, goes to RESP with rsp_err=1 and rsp_rdata=0.
- Reset mid-operation: immediate return to IDLE, mem_req=0, no rsp_valid.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined: H with addr[0]=1, or W with addr[1:0]!=0, is misaligned. No memory access; rsp_valid one cycle after accept with rsp_err=1, rsp_rdata=0.
- Undefined: misaligned low bits are ignored. H uses addr[1] only; W uses the word address. The access proceeds and rsp_err=0.

Decomposition:
- MEM_* codes added to define.sv beside the existing control encodings, so decode and this unit share one source.
- lsu_pkg holds the state enum (IDLE, REQ, WAIT, RESP) and the lane-enable constants.
- One combinational sub-module, lsu_lane_align: produces store be/wdata and load extract/extend from ctrl, offset and data.

Test Plan:
- sb addr 0x1003, wdata 0x000000AB, gnt immediate -> mem_addr 0x1000, be 1000, wdata 0xABABABAB, rsp_valid at T+2, rsp_err=0.
- lb addr 0x2002, mem_rdata 0x12F45678 -> rsp_rdata 0xFFFFFFF4. lbu, same data -> 0x000000F4.
- lh addr 0x2002, mem_rdata 0x80011234 -> 0xFFFF8001. lhu -> 0x00008001. sh addr 0x2002 -> be 1100.
- mem_gnt withheld 3 cycles on sw -> mem_req/addr/be/wdata stable 4 cycles, req_ready=0, single rsp_valid.
- lw addr 0x2001:
  - With LSU_MISALIGN_TRAP_EN: no mem_req, rsp_err=1, rdata 0 at T+1.
  - Without: mem_addr 0x2000, be 1111, full word returned.
- TIMEOUT_CYCLES=8, load never gets rvalid -> rsp_err=1 after 8 cycles. Separately, rst_n pulsed low in WAIT -> IDLE, mem_req=0, no rsp_valid; req_ready=1 after release.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: MemCtrl codes, FSM states, lane enables.
package lsu_pkg;

  // MemCtrl size/extension codes, shared with instruction decode
  localparam logic [2:0] MEM_B  = 3'b000;
  localparam logic [2:0] MEM_H  = 3'b001;
  localparam logic [2:0] MEM_W  = 3'b010;
  localparam logic [2:0] MEM_BU = 3'b100;
  localparam logic [2:0] MEM_HU = 3'b101;

  // Byte-lane enable patterns
  localparam logic [3:0] BE_BYTE0   = 4'b0001;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_WORD    = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } lsu_state_e;

  // True for the five defined MemCtrl codes
  function automatic logic ctrl_legal(input logic [2:0] ctrl);
    case (ctrl)
      MEM_B, MEM_H, MEM_W, MEM_BU, MEM_HU: return 1'b1;
      default:                             return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Store lane steering (byte enables, replicated data) and load extract/extend.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [2:0]  ctrl,
  input  logic [1:0]  offset,
  input  logic [31:0] store_data,
  input  logic [31:0] load_word,
  output logic [3:0]  be_c,
  output logic [31:0] wdata_c,
  output logic [31:0] rdata_c
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // ctrl[1:0] selects size, ctrl[2] selects zero extension; stores ignore ctrl[2]
  always_comb begin
    be_c     = BE_WORD;
    wdata_c  = store_data;
    rdata_c  = load_word;
    half_sel = offset[1] ? load_word[31:16] : load_word[15:0];
    case (offset)
      2'd0:    byte_sel = load_word[7:0];
      2'd1:    byte_sel = load_word[15:8];
      2'd2:    byte_sel = load_word[23:16];
      default: byte_sel = load_word[31:24];
    endcase
    case (ctrl[1:0])
      2'b00: begin
        be_c    = BE_BYTE0 << offset;
        wdata_c = {4{store_data[7:0]}};
        rdata_c = ctrl[2] ? {24'd0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      end
      2'b01: begin
        be_c    = offset[1] ? BE_HALF_HI : BE_HALF_LO;
        wdata_c = {2{store_data[15:0]}};
        rdata_c = ctrl[2] ? {16'd0, half_sel} : {{16{half_sel[15]}}, half_sel};
      end
      default: begin
        be_c    = BE_WORD;
        wdata_c = store_data;
        rdata_c = load_word;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts MemWrite/MemCtrl commands and runs byte/half/word
// accesses against a word-addressed data memory with grant/rvalid handshake.
// Optional LSU_MISALIGN_TRAP_EN: misaligned H/W commands complete with rsp_err
// and no memory access; otherwise low address bits are ignored.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [2:0]            req_ctrl,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [3:0]            mem_be,
  output logic [31:0]           mem_wdata,
  input  logic                  mem_gnt,
  input  logic                  mem_rvalid,
  input  logic [31:0]           mem_rdata
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  lsu_state_e       state_q, state_d;
  logic [2:0]       ctrl_q;
  logic [1:0]       off_q;
  logic [CNT_W-1:0] cnt_q;

  logic             accept_c, misalign_c, cmd_err_c, timeout_c, load_cmd_c;
  logic             rsp_err_d;
  logic [31:0]      rsp_rdata_d;
  logic [2:0]       align_ctrl_c;
  logic [1:0]       align_off_c;
  logic [3:0]       be_c;
  logic [31:0]      wdata_c, rdata_c;

  assign accept_c = req_valid && req_ready;

`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign_c = ((req_ctrl[1:0] == 2'b01) && req_addr[0]) ||
                      ((req_ctrl[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`else
  assign misalign_c = 1'b0;
`endif

  assign cmd_err_c = !ctrl_legal(req_ctrl) || misalign_c;
  assign timeout_c = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // Steer incoming command while idle; latched command while the load is outstanding
  assign align_ctrl_c = (state_q == IDLE) ? req_ctrl : ctrl_q;
  assign align_off_c  = (state_q == IDLE) ? req_addr[1:0] : off_q;

  lsu_lane_align u_align (
    .ctrl       (align_ctrl_c),
    .offset     (align_off_c),
    .store_data (req_wdata),
    .load_word  (mem_rdata),
    .be_c       (be_c),
    .wdata_c    (wdata_c),
    .rdata_c    (rdata_c)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state and response payload; progress beats timeout in the same cycle
  always_comb begin
    state_d     = state_q;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = 32'd0;
    load_cmd_c  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept_c) begin
          if (cmd_err_c) begin
            state_d   = RESP;
            rsp_err_d = 1'b1;
          end else begin
            state_d    = REQ;
            load_cmd_c = 1'b1;
          end
        end
      end
      REQ: begin
        if (mem_gnt) begin
          state_d = mem_we ? RESP : WAIT;
        end else if (timeout_c) begin
          state_d   = RESP;
          rsp_err_d = 1'b1;
        end
      end
      WAIT: begin
        if (mem_rvalid) begin
          state_d     = RESP;
          rsp_rdata_d = rdata_c;
        end else if (timeout_c) begin
          state_d   = RESP;
          rsp_err_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Registered outputs and latched command; mem_we doubles as the store flag in REQ
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= 32'd0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= 4'd0;
      mem_wdata <= 32'd0;
      ctrl_q    <= 3'd0;
      off_q     <= 2'd0;
    end else begin
      req_ready <= (state_d == IDLE);
      rsp_valid <= (state_d == RESP);
      rsp_err   <= rsp_err_d;
      rsp_rdata <= rsp_rdata_d;
      mem_req   <= (state_d == REQ);
      if (load_cmd_c) begin
        mem_we    <= req_write;
        mem_addr  <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
        mem_be    <= be_c;
        mem_wdata <= wdata_c;
        ctrl_q    <= req_ctrl;
        off_q     <= req_addr[1:0];
      end else if (state_d != REQ) begin
        mem_we <= 1'b0;
      end
    end
  end

  // Timeout counter: cleared on entry to REQ, counts every REQ/WAIT cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                 cnt_q <= '0;
    else if (load_cmd_c)                        cnt_q <= '0;
    else if (state_q == REQ || state_q == WAIT) cnt_q <= cnt_q + CNT_W'(1);
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized self-checking bench for load_store_unit with a behavioural memory model.
module tb_load_store_unit;

  localparam int unsigned TO = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_write;
  logic [2:0]  req_ctrl;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          rsp_cnt;
    int          rsp_k;
    logic [31:0] rdata;
    logic        err;
    int          req_cnt;
    logic [31:0] maddr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        we;
    bit          stable;
    bit          ready_busy;
    logic        ready_end;
  } op_res_t;

  load_store_unit #(.ADDR_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_ctrl(req_ctrl), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic bit exp_err(input bit [2:0] c, input bit [31:0] a);
    bit e;
    e = (c == 3) || (c == 6) || (c == 7);
`ifdef LSU_MISALIGN_TRAP_EN
    if ((c % 4) == 1 && (a % 2) != 0) e = 1;
    if ((c % 4) == 2 && (a % 4) != 0) e = 1;
`endif
    return e;
  endfunction

  function automatic bit [3:0] exp_be(input bit [2:0] c, input bit [31:0] a);
    int o;
    o = int'(a % 4);
    if ((c % 4) == 0) return 4'(1 << o);
    if ((c % 4) == 1) return (o >= 2) ? 4'hC : 4'h3;
    return 4'hF;
  endfunction

  function automatic bit [31:0] exp_wdata(input bit [2:0] c, input bit [31:0] d);
    if ((c % 4) == 0) return (d % 256) * 32'h0101_0101;
    if ((c % 4) == 1) return (d % 65536) * 32'h0001_0001;
    return d;
  endfunction

  function automatic bit [31:0] exp_load(input bit [2:0] c, input bit [31:0] a, input bit [31:0] w);
    bit [31:0] v;
    if ((c % 4) == 0) begin
      v = (w >> (8 * (a % 4))) % 256;
      if (c < 4 && v >= 128) v = v - 256;
      return v;
    end
    if ((c % 4) == 1) begin
      v = (w >> (16 * ((a % 4) / 2))) % 65536;
      if (c < 4 && v >= 32768) v = v - 65536;
      return v;
    end
    return w;
  endfunction

  // ---------------- driver + memory responder ----------------
  // gnt_dly/rv_dly < 0 means never respond. Returns at the cycle after the response.
  task automatic run_op(input logic w, input logic [2:0] c, input logic [31:0] a,
                        input logic [31:0] d, input int gnt_dly, input int rv_dly,
                        input logic [31:0] rd, output op_res_t r);
    bit granted;
    int grant_k;
    r.rsp_cnt = 0; r.rsp_k = 0; r.rdata = 32'd0; r.err = 1'b0; r.req_cnt = 0;
    r.maddr = 32'd0; r.be = 4'd0; r.wdata = 32'd0; r.we = 1'b0;
    r.stable = 1'b1; r.ready_busy = 1'b0; r.ready_end = 1'b0;
    granted = 1'b0; grant_k = 0;
    req_valid = 1'b1; req_write = w; req_ctrl = c; req_addr = a; req_wdata = d;
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; req_write = 1'($urandom); req_ctrl = 3'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
    for (int k = 1; k <= 40; k++) begin
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = $urandom;
      if (req_ready && r.rsp_k == 0) r.ready_busy = 1'b1;
      if (rsp_valid) begin
        r.rsp_cnt++;
        if (r.rsp_k == 0) begin r.rsp_k = k; r.rdata = rsp_rdata; r.err = rsp_err; end
      end
      if (mem_req) begin
        r.req_cnt++;
        if (r.req_cnt == 1) begin
          r.maddr = mem_addr; r.be = mem_be; r.wdata = mem_wdata; r.we = mem_we;
        end else if (mem_addr !== r.maddr || mem_be !== r.be || mem_wdata !== r.wdata || mem_we !== r.we) begin
          r.stable = 1'b0;
        end
        mem_rvalid = 1'($urandom);
        if (!granted && gnt_dly >= 0 && r.req_cnt > gnt_dly) begin
          mem_gnt = 1'b1; granted = 1'b1; grant_k = k;
        end
      end
      if (granted && !w && rv_dly >= 0 && k == grant_k + 1 + rv_dly) begin
        mem_rvalid = 1'b1; mem_rdata = rd;
      end
      r.ready_end = req_ready;
      if (r.rsp_k != 0 && k >= r.rsp_k + 1) break;
      @(negedge clk);
    end
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_ctrl = 3'd0; req_addr = 32'd0;
    req_wdata = 32'd0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0;
    repeat (3) @(negedge clk);
    checks++;
    if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b exp 0", req_ready); end
    checks++;
    if ({rsp_valid, rsp_err, rsp_rdata, mem_req, mem_we, mem_addr, mem_be, mem_wdata} !== '0) begin
      errors++; $display("FAIL reset_outputs got %b%b %h %b%b %h %h %h exp all 0",
                         rsp_valid, rsp_err, rsp_rdata, mem_req, mem_we, mem_addr, mem_be, mem_wdata);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready got %b exp 1", req_ready); end
  endtask

  task automatic test_store_byte();
    op_res_t r;
    run_op(1'b1, 3'b000, 32'h0000_1003, 32'h0000_00AB, 0, 0, 32'd0, r);
    checks++; if (r.maddr !== 32'h0000_1000) begin errors++; $display("FAIL sb_addr got %h exp 00001000", r.maddr); end
    checks++; if (r.be !== 4'b1000) begin errors++; $display("FAIL sb_be got %b exp 1000", r.be); end
    checks++; if (r.wdata !== 32'hABAB_ABAB) begin errors++; $display("FAIL sb_wdata got %h exp abababab", r.wdata); end
    checks++; if (r.we !== 1'b1) begin errors++; $display("FAIL sb_we got %b exp 1", r.we); end
    checks++; if (r.rsp_k != 2) begin errors++; $display("FAIL sb_latency got %0d exp 2", r.rsp_k); end
    checks++; if (r.err !== 1'b0 || r.rdata !== 32'd0) begin errors++; $display("FAIL sb_rsp got err=%b rdata=%h exp 0/0", r.err, r.rdata); end
  endtask

  task automatic test_sub_word();
    logic [2:0]  lc [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
    logic [31:0] lw [4] = '{32'h12F4_5678, 32'h12F4_5678, 32'h8001_1234, 32'h8001_1234};
    logic [31:0] lx [4] = '{32'hFFFF_FFF4, 32'h0000_00F4, 32'hFFFF_8001, 32'h0000_8001};
    op_res_t r;
    for (int i = 0; i < 4; i++) begin
      run_op(1'b0, lc[i], 32'h0000_2002, 32'd0, 0, 0, lw[i], r);
      checks++; if (r.rdata !== lx[i]) begin errors++; $display("FAIL load%0d_rdata got %h exp %h", i, r.rdata, lx[i]); end
      checks++; if (r.rsp_k != 3 || r.we !== 1'b0) begin errors++; $display("FAIL load%0d_timing got k=%0d we=%b exp 3/0", i, r.rsp_k, r.we); end
    end
    run_op(1'b1, 3'b001, 32'h0000_2002, 32'hDEAD_BEEF, 0, 0, 32'd0, r);
    checks++; if (r.be !== 4'b1100) begin errors++; $display("FAIL sh_be got %b exp 1100", r.be); end
    checks++; if (r.wdata !== 32'hBEEF_BEEF) begin errors++; $display("FAIL sh_wdata got %h exp beefbeef", r.wdata); end
  endtask

  task automatic test_gnt_stall();
    op_res_t r;
    run_op(1'b1, 3'b010, 32'h0000_4000, 32'h1234_5678, 3, 0, 32'd0, r);
    checks++; if (r.req_cnt != 4) begin errors++; $display("FAIL stall_req_cycles got %0d exp 4", r.req_cnt); end
    checks++; if (!r.stable) begin errors++; $display("FAIL stall_stable got 0 exp 1"); end
    checks++; if (r.ready_busy) begin errors++; $display("FAIL stall_ready_busy got 1 exp 0"); end
    checks++; if (r.rsp_cnt != 1 || r.rsp_k != 5) begin errors++; $display("FAIL stall_rsp got cnt=%0d k=%0d exp 1/5", r.rsp_cnt, r.rsp_k); end
  endtask

  task automatic test_misalign();
    op_res_t r;
    run_op(1'b0, 3'b010, 32'h0000_2001, 32'd0, 0, 0, 32'hCAFE_F00D, r);
`ifdef LSU_MISALIGN_TRAP_EN
    checks++; if (r.req_cnt != 0) begin errors++; $display("FAIL misalign_memreq got %0d exp 0", r.req_cnt); end
    checks++; if (r.rsp_k != 1 || r.err !== 1'b1 || r.rdata !== 32'd0) begin
      errors++; $display("FAIL misalign_rsp got k=%0d err=%b rdata=%h exp 1/1/0", r.rsp_k, r.err, r.rdata); end
`else
    checks++; if (r.maddr !== 32'h0000_2000 || r.be !== 4'hF) begin
      errors++; $display("FAIL misalign_mem got %h/%b exp 00002000/1111", r.maddr, r.be); end
    checks++; if (r.rsp_k != 3 || r.err !== 1'b0 || r.rdata !== 32'hCAFE_F00D) begin
      errors++; $display("FAIL misalign_rsp got k=%0d err=%b rdata=%h exp 3/0/cafef00d", r.rsp_k, r.err, r.rdata); end
`endif
  endtask

  task automatic test_illegal();
    logic [2:0] bad [3] = '{3'b011, 3'b110, 3'b111};
    op_res_t r;
    for (int i = 0; i < 3; i++) begin
      run_op(1'(i % 2), bad[i], $urandom, $urandom, 0, 0, $urandom, r);
      checks++; if (r.req_cnt != 0 || r.rsp_k != 1 || r.err !== 1'b1 || r.rdata !== 32'd0) begin
        errors++; $display("FAIL illegal%0d got req=%0d k=%0d err=%b rdata=%h exp 0/1/1/0", i, r.req_cnt, r.rsp_k, r.err, r.rdata); end
    end
  endtask

  task automatic test_random();
    op_res_t r;
    for (int n = 0; n < 60; n++) begin
      logic        w;
      logic [2:0]  c;
      logic [31:0] a, d, word;
      int          g, v, ek;
      bit          e;
      w = 1'($urandom); c = 3'($urandom); a = $urandom; d = $urandom; word = $urandom;
      g = $urandom_range(0, 2); v = $urandom_range(0, 3);
      run_op(w, c, a, d, g, v, word, r);
      e  = exp_err(c, a);
      ek = e ? 1 : (w ? 2 + g : 3 + g + v);
      checks++; if (r.rsp_cnt != 1 || r.rsp_k != ek) begin
        errors++; $display("FAIL rand%0d_timing got cnt=%0d k=%0d exp 1/%0d", n, r.rsp_cnt, r.rsp_k, ek); end
      checks++; if (r.err !== e) begin errors++; $display("FAIL rand%0d_err got %b exp %b", n, r.err, e); end
      checks++; if (r.rdata !== ((e || w) ? 32'd0 : exp_load(c, a, word))) begin
        errors++; $display("FAIL rand%0d_rdata got %h exp %h", n, r.rdata, (e || w) ? 32'd0 : exp_load(c, a, word)); end
      if (!e) begin
        checks++; if (r.maddr !== (a & 32'hFFFF_FFFC) || r.be !== exp_be(c, a) || r.we !== w || !r.stable) begin
          errors++; $display("FAIL rand%0d_mem got %h/%b/%b/%b exp %h/%b/%b/1", n, r.maddr, r.be, r.we, r.stable,
                             a & 32'hFFFF_FFFC, exp_be(c, a), w); end
        if (w) begin
          checks++; if (r.wdata !== exp_wdata(c, d)) begin
            errors++; $display("FAIL rand%0d_wdata got %h exp %h", n, r.wdata, exp_wdata(c, d)); end
        end
      end else begin
        checks++; if (r.req_cnt != 0) begin errors++; $display("FAIL rand%0d_noaccess got %0d exp 0", n, r.req_cnt); end
      end
    end
  endtask

  task automatic test_back_to_back();
    op_res_t r;
    for (int n = 0; n < 6; n++) begin
      run_op(1'(n % 2), 3'b010, 32'h100 * n, $urandom, 0, 0, 32'h5555_0000 + n, r);
      checks++; if (r.ready_end !== 1'b1 || r.rsp_cnt != 1) begin
        errors++; $display("FAIL b2b%0d got ready=%b cnt=%0d exp 1/1", n, r.ready_end, r.rsp_cnt); end
    end
  endtask

  task automatic test_timeout();
    op_res_t r;
    run_op(1'b0, 3'b010, 32'h0000_6000, 32'd0, 0, -1, 32'd0, r);
    checks++; if (r.rsp_k != int'(TO) + 1 || r.err !== 1'b1 || r.rdata !== 32'd0) begin
      errors++; $display("FAIL timeout_load got k=%0d err=%b rdata=%h exp %0d/1/0", r.rsp_k, r.err, r.rdata, TO + 1); end
    // late data after the timeout must be dropped
    mem_rvalid = 1'b1; mem_rdata = 32'hBAD0_BAD0;
    @(negedge clk);
    mem_rvalid = 1'b0;
    checks++; if (rsp_valid !== 1'b0 || mem_req !== 1'b0) begin
      errors++; $display("FAIL timeout_late got rsp=%b req=%b exp 0/0", rsp_valid, mem_req); end
    run_op(1'b1, 3'b010, 32'h0000_6004, 32'h1, -1, 0, 32'd0, r);
    checks++; if (r.req_cnt != int'(TO) || r.rsp_k != int'(TO) + 1 || r.err !== 1'b1) begin
      errors++; $display("FAIL timeout_gnt got req=%0d k=%0d err=%b exp %0d/%0d/1", r.req_cnt, r.rsp_k, r.err, TO, TO + 1); end
  endtask

  task automatic test_reset_mid();
    req_valid = 1'b1; req_write = 1'b0; req_ctrl = 3'b010; req_addr = 32'h0000_3000;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++; if (mem_req !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b0) begin
      errors++; $display("FAIL midreset_outputs got req=%b rsp=%b rdy=%b exp 0/0/0", mem_req, rsp_valid, req_ready); end
    mem_rvalid = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (rsp_valid !== 1'b0 || mem_req !== 1'b0) begin
        errors++; $display("FAIL midreset_quiet%0d got rsp=%b req=%b exp 0/0", i, rsp_valid, mem_req); end
    end
    mem_rvalid = 1'b0;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL midreset_ready got %b exp 1", req_ready); end
  endtask

  initial begin
    test_reset();
    test_store_byte();
    test_sub_word();
    test_gnt_stall();
    test_misalign();
    test_illegal();
    test_random();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
